load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage downstream of the ALU. Takes ALU_result as the effective address, plus funct3 and rs2 data.
//  Runs one RV32I load/store at a time over a req/gnt/rvalid data-memory port. Stalls the pipeline until done.
//  Handles byte-lane alignment and sign/zero extension, with a bus timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  256  cycles waited in REQ or WAIT_RD before aborting with bus_err; 0 = never time out
// PORTS
//  clk         in   1   single clock, rising edge
//  reset       in   1   synchronous, active-high
//  start       in   1   memory op valid from execute (sampled in IDLE only)
//  is_load     in   1   op is a load (wins if is_store also set)
//  is_store    in   1   op is a store
//  funct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (stores: 000/001/010 only)
//  addr        in   32  effective address (ALU_result)
//  store_data  in   32  rs2 value
//  stall       out  1   comb: (IDLE & start & (is_load|is_store)) | state in {REQ,WAIT_RD}
//  done        out  1   1-cycle pulse, op complete
//  load_data   out  32  extended load result; updates only on load completion
//  misaligned  out  1   valid with done
//  bus_err     out  1   valid with done: timeout
//  mem_req     out  1   request; held high until mem_gnt
//  mem_we      out  1   1 = write
//  mem_addr    out  32  word address: {addr[31:2],2'b00}
//  mem_be      out  4   byte enables
//  mem_wdata   out  32  lane-replicated write data
//  mem_gnt     in   1   request accepted this cycle
//  mem_rvalid  in   1   read data valid; earliest the cycle after gnt
//  mem_rdata   in   32  read data
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0. Takes effect mid-op on the same edge. A later rvalid is ignored.
//  FSM IDLE->REQ on start with is_load|is_store; start with neither, or start outside IDLE, is ignored.
//  In IDLE, latch funct3, addr[1:0] and the load/store flag; register the mem_* outputs.
//  REQ: mem_req=1 and mem_* stable. On gnt, a store goes ->DONE and a load goes ->WAIT_RD.
//  WAIT_RD: on rvalid, capture the extended rdata into load_data, then ->DONE. DONE: done=1 for one cycle, then ->IDLE.
//  Latency from start cycle with zero-wait memory: store done at +2, load done at +3.
//  Store lanes:
//   SB: wdata={4{sd[7:0]}}, be=4'b0001<<a[1:0]
//   SH: {2{sd[15:0]}}, be=4'b0011<<{a[1],0}
//   SW: sd, be=4'b1111
//  Load extract: shift rdata right by 8*a[1:0]. B/H sign-extend; BU/HU zero-extend; W as is.
//  Illegal funct3 (load 011/110/111, store >=011): no memory access; IDLE->DONE; load writes load_data=0.
//  Timeout: cycle counter cleared on entry to REQ and WAIT_RD. It reaches TIMEOUT_CYCLES with no gnt/rvalid
//   -> mem_req drops, ->DONE with bus_err=1, load_data unchanged.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: H with a[0]=1, or W with a[1:0]!=0, makes no memory access.
//   It goes IDLE->DONE with misaligned=1; load_data is unchanged.
//  Not defined: misalignment is ignored and the offending low address bits are forced to 0.
//   The access proceeds normally; misaligned is tied to 0.
// STRUCTURE
//  lsu_pkg:
//   funct3 localparams (F3_B,F3_H,F3_W,F3_BU,F3_HU)
//   typedef enum logic[1:0] lsu_state_t {IDLE,REQ,WAIT_RD,DONE}
//  Sub-module lsu_lane: comb store-lane replication/BE generation and load extraction/extension.
//  FSM, timeout counter and output registers stay in load_store_unit.
// TESTING
//  1. SB addr=0x1003 sd=0x000000A5, gnt in REQ -> mem_addr=0x1000, be=1000, wdata=A5A5A5A5, done at +2.
//  2. LB addr=0x2001, rdata=0x0000_80FF one cycle after gnt -> load_data=0xFFFFFF80.
//     LBU with the same stimulus -> 0x00000080.
//  3. LH addr=0x2002 with gnt delayed 3 cycles, rdata=0x8001_1234 -> mem_req held 4 cycles, load_data=0xFFFF8001, stall high until done.
//  4. LW addr=0x3002: with LSU_MISALIGN_TRAP_EN, done+misaligned at +1 and mem_req never rises.
//     Without it, mem_addr=0x3000.
//  5. TIMEOUT_CYCLES=4, LW with no gnt -> mem_req high 4 cycles, then done with bus_err=1.
//     A late rvalid afterwards is ignored.
//  6. reset asserted in WAIT_RD -> next cycle IDLE, all outputs 0; a following rvalid does not change load_data.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared funct3 encodings, FSM state type and small decode helpers
//            for the RV32I load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT_RD = 2'd2,
      DONE    = 2'd3
   } lsu_state_t;

   // Loads accept signed and unsigned B/H plus W; stores only B/H/W.
   function automatic logic f3_legal(input logic is_ld, input logic [2:0] f3);
      if (is_ld)
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                (f3 == F3_BU) || (f3 == F3_HU);
      else
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
   endfunction

   // Access size lives in funct3[1:0]: 00 byte, 01 half, 10 word.
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         2'b01:   return off[0];
         2'b10:   return off != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   // Clears the low offset bits a half/word access is not allowed to use.
   function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] off);
      case (sz)
         2'b01:   return {off[1], 1'b0};
         2'b10:   return 2'b00;
         default: return off;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane
// Brief    : Combinational byte-lane logic: store data replication and byte
//            enables, load data extraction with sign/zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_off,
   input  logic [31:0] st_data,
   output logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_off,
   input  logic [31:0] ld_rdata,
   output logic [31:0] ld_result
);

   logic [31:0] w_shifted;

   // Store side: replicate the datum into every lane, enable only its bytes.
   always_comb begin
      st_wdata = st_data;
      st_be    = 4'b1111;
      case (st_size)
         2'b00: begin
            st_wdata = {4{st_data[7:0]}};
            st_be    = 4'b0001 << st_off;
         end
         2'b01: begin
            st_wdata = {2{st_data[15:0]}};
            st_be    = 4'b0011 << {st_off[1], 1'b0};
         end
         default: begin
            st_wdata = st_data;
            st_be    = 4'b1111;
         end
      endcase
   end

   assign w_shifted = ld_rdata >> {ld_off, 3'b000};

   // Load side: bring the addressed bytes down to bit 0, then extend.
   always_comb begin
      ld_result = w_shifted;
      case (ld_funct3)
         F3_B:    ld_result = {{24{w_shifted[7]}}, w_shifted[7:0]};
         F3_H:    ld_result = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_BU:   ld_result = {24'h0, w_shifted[7:0]};
         F3_HU:   ld_result = {16'h0, w_shifted[15:0]};
         default: ld_result = w_shifted;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Single-outstanding RV32I load/store engine over a req/gnt/rvalid
//            data-memory port, with lane alignment and a bus timeout.
//            Optional macro LSU_MISALIGN_TRAP_EN: misaligned H/W accesses
//            complete without touching memory and flag misaligned; when
//            undefined the offending low address bits are forced to zero.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_load,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        stall,
   output logic        done,
   output logic [31:0] load_data,
   output logic        misaligned,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam int C_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [C_CNT_W-1:0] C_CNT_LAST =
      (TIMEOUT_CYCLES > 0) ? C_CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   lsu_state_t        state_q, state_d;
   logic [C_CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [1:0]        off_q, off_d;
   logic              is_load_q, is_load_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [31:0]       load_data_q, load_data_d;
   logic              misaligned_q, misaligned_d;
   logic              bus_err_q, bus_err_d;

   logic              w_op;
   logic              w_legal;
   logic              w_mis;
   logic              w_to_hit;
   logic [1:0]        w_off;
   logic [31:0]       w_st_wdata;
   logic [3:0]        w_st_be;
   logic [31:0]       w_ld_ext;

   assign w_op     = is_load | is_store;
   assign w_legal  = f3_legal(is_load, funct3);
   assign w_off    = align_off(funct3[1:0], addr[1:0]);
   assign w_to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == C_CNT_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_mis = is_misaligned(funct3[1:0], addr[1:0]);
`else
   assign w_mis = 1'b0;
`endif

   lsu_lane u_lane (
      .st_size   (funct3[1:0]),
      .st_off    (w_off),
      .st_data   (store_data),
      .st_wdata  (w_st_wdata),
      .st_be     (w_st_be),
      .ld_funct3 (funct3_q),
      .ld_off    (off_q),
      .ld_rdata  (mem_rdata),
      .ld_result (w_ld_ext)
   );

   // Next-state, timeout counter and registered-output updates.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      is_load_d    = is_load_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      load_data_d  = load_data_q;
      misaligned_d = misaligned_q;
      bus_err_d    = bus_err_q;
      case (state_q)
         IDLE: begin
            misaligned_d = 1'b0;
            bus_err_d    = 1'b0;
            if (start && w_op) begin
               funct3_d  = funct3;
               off_d     = w_off;
               is_load_d = is_load;
               if (!w_legal) begin
                  state_d = DONE;
                  if (is_load)
                     load_data_d = 32'h0;
               end else if (w_mis) begin
                  state_d      = DONE;
                  misaligned_d = 1'b1;
               end else begin
                  state_d     = REQ;
                  cnt_d       = '0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = ~is_load;
                  mem_addr_d  = {addr[31:2], 2'b00};
                  mem_be_d    = w_st_be;
                  mem_wdata_d = is_load ? 32'h0 : w_st_wdata;
               end
            end
         end
         REQ: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               cnt_d     = '0;
               state_d   = is_load_q ? WAIT_RD : DONE;
            end else if (w_to_hit) begin
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + C_CNT_W'(1);
            end
         end
         WAIT_RD: begin
            if (mem_rvalid) begin
               load_data_d = w_ld_ext;
               state_d     = DONE;
            end else if (w_to_hit) begin
               bus_err_d = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + C_CNT_W'(1);
            end
         end
         default: begin
            misaligned_d = 1'b0;
            bus_err_d    = 1'b0;
            state_d      = IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any in-flight op.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         funct3_q     <= 3'b000;
         off_q        <= 2'b00;
         is_load_q    <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'h0;
         mem_be_q     <= 4'h0;
         mem_wdata_q  <= 32'h0;
         load_data_q  <= 32'h0;
         misaligned_q <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         is_load_q    <= is_load_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         load_data_q  <= load_data_d;
         misaligned_q <= misaligned_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign stall      = ((state_q == IDLE) && start && w_op) ||
                       (state_q == REQ) || (state_q == WAIT_RD);
   assign done       = (state_q == DONE);
   assign load_data  = load_data_q;
   assign misaligned = misaligned_q;
   assign bus_err    = bus_err_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Self-checking bench for load_store_unit; a scoreboard queue holds
//            the expected completion of each issued op.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset, start, is_load, is_store;
   logic [2:0]  funct3;
   logic [31:0] addr, store_data;
   logic        stall, done, misaligned, bus_err;
   logic [31:0] load_data;
   logic        mem_req, mem_we, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] ld;
      logic        mis;
      logic        berr;
      int          lat;
   } exp_t;

   typedef struct {
      int          lat;
      int          req;
      int          stall_lo;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        we;
      logic [31:0] ld;
      logic        mis;
      logic        berr;
      logic        stall_done;
      logic        done_next;
   } obs_t;

   exp_t        exp_q[$];
   logic [31:0] model_ld;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .start(start), .is_load(is_load), .is_store(is_store),
      .funct3(funct3), .addr(addr), .store_data(store_data), .stall(stall), .done(done),
      .load_data(load_data), .misaligned(misaligned), .bus_err(bus_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
      start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
      #1;
   endtask

   // Plays the memory side after an issue; gnt after gnt_wait extra REQ cycles,
   // rvalid the cycle after gnt. Bounded to 40 cycles (lat stays -1 on expiry).
   task automatic serve(input int gnt_wait, input bit give_gnt, input bit give_rv,
                        input logic [31:0] rdata, output obs_t o);
      int since_g;
      since_g = -1;
      o.lat = -1; o.req = 0; o.stall_lo = 0; o.addr = '0; o.be = '0; o.wdata = '0;
      o.we = 1'b0; o.ld = '0; o.mis = 1'b0; o.berr = 1'b0; o.stall_done = 1'b0; o.done_next = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(posedge clk); #1;
         start = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
         if (done) begin
            o.lat = cyc; o.ld = load_data; o.mis = misaligned; o.berr = bus_err; o.stall_done = stall;
            break;
         end
         if (!stall) o.stall_lo++;
         if (since_g >= 0) since_g++;
         if (mem_req) begin
            o.req++; o.addr = mem_addr; o.be = mem_be; o.wdata = mem_wdata; o.we = mem_we;
            if (give_gnt && o.req == gnt_wait + 1) begin mem_gnt = 1'b1; since_g = 0; end
         end
         if (give_rv && since_g == 1) begin mem_rvalid = 1'b1; mem_rdata = rdata; end
      end
      if (o.lat > 0) begin
         @(posedge clk); #1;
         o.done_next = done;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b0;
      addr = '0; store_data = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if ({stall, done, misaligned, bus_err, mem_req, mem_we} !== 6'b0) begin failures++;
         $display("FAIL reset_ctrl got=%b want=000000", {stall, done, misaligned, bus_err, mem_req, mem_we}); end
      checks++; if ({load_data, mem_addr, mem_be, mem_wdata} !== 100'b0) begin failures++;
         $display("FAIL reset_data ld=%h addr=%h be=%h wd=%h want all 0", load_data, mem_addr, mem_be, mem_wdata); end
      reset = 1'b0;
      model_ld = 32'h0;
   endtask

   task automatic test_store_lanes;
      logic [2:0]  f3s [4] = '{3'b000, 3'b001, 3'b010, 3'b000};
      logic [31:0] as  [4] = '{32'h1003, 32'h1002, 32'h1004, 32'h1000};
      logic [31:0] sds [4] = '{32'h0000_00A5, 32'h1234_ABCD, 32'hDEAD_BEEF, 32'h0000_0077};
      logic [3:0]  bes [4] = '{4'b1000, 4'b1100, 4'b1111, 4'b0001};
      logic [31:0] wds [4] = '{32'hA5A5_A5A5, 32'hABCD_ABCD, 32'hDEAD_BEEF, 32'h7777_7777};
      obs_t o;
      exp_t e;
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, 1'b1, f3s[i], as[i], sds[i]);
         checks++; if (stall !== 1'b1) begin failures++; $display("FAIL st%0d_stall_start got=%b want=1", i, stall); end
         exp_q.push_back('{ld: model_ld, mis: 1'b0, berr: 1'b0, lat: 2});
         serve(0, 1'b1, 1'b0, 32'h0, o);
         e = exp_q.pop_front();
         checks++; if (o.lat !== e.lat) begin failures++; $display("FAIL st%0d_latency got=%0d want=%0d", i, o.lat, e.lat); end
         checks++; if (o.addr !== (as[i] & 32'hFFFF_FFFC)) begin failures++; $display("FAIL st%0d_addr got=%h want=%h", i, o.addr, as[i] & 32'hFFFF_FFFC); end
         checks++; if (o.be !== bes[i]) begin failures++; $display("FAIL st%0d_be got=%b want=%b", i, o.be, bes[i]); end
         checks++; if (o.wdata !== wds[i]) begin failures++; $display("FAIL st%0d_wdata got=%h want=%h", i, o.wdata, wds[i]); end
         checks++; if (o.we !== 1'b1) begin failures++; $display("FAIL st%0d_we got=%b want=1", i, o.we); end
         checks++; if ({o.ld, o.mis, o.berr} !== {e.ld, e.mis, e.berr}) begin failures++;
            $display("FAIL st%0d_result ld=%h mis=%b berr=%b want ld=%h mis=%b berr=%b", i, o.ld, o.mis, o.berr, e.ld, e.mis, e.berr); end
         checks++; if ({o.done_next, o.stall_done, o.stall_lo != 0} !== 3'b000) begin failures++;
            $display("FAIL st%0d_pulse done_next=%b stall_done=%b stall_lo=%0d want 0", i, o.done_next, o.stall_done, o.stall_lo); end
      end
   endtask

   task automatic test_load_extend;
      logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b101};
      logic [31:0] exs [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
      logic [31:0] as  [3] = '{32'h2001, 32'h2001, 32'h2000};
      obs_t o;
      exp_t e;
      for (int i = 0; i < 3; i++) begin
         issue(1'b1, 1'b0, f3s[i], as[i], 32'h0);
         model_ld = exs[i];
         exp_q.push_back('{ld: model_ld, mis: 1'b0, berr: 1'b0, lat: 3});
         serve(0, 1'b1, 1'b1, 32'h0000_80FF, o);
         e = exp_q.pop_front();
         checks++; if (o.lat !== e.lat) begin failures++; $display("FAIL ld%0d_latency got=%0d want=%0d", i, o.lat, e.lat); end
         checks++; if (o.ld !== e.ld) begin failures++; $display("FAIL ld%0d_data got=%h want=%h", i, o.ld, e.ld); end
         checks++; if ({o.we, o.mis, o.berr} !== 3'b000) begin failures++; $display("FAIL ld%0d_flags we=%b mis=%b berr=%b want 0", i, o.we, o.mis, o.berr); end
      end
   endtask

   task automatic test_gnt_delay;
      obs_t o;
      exp_t e;
      issue(1'b1, 1'b0, 3'b001, 32'h2002, 32'h0);
      model_ld = 32'hFFFF_8001;
      exp_q.push_back('{ld: model_ld, mis: 1'b0, berr: 1'b0, lat: 6});
      serve(3, 1'b1, 1'b1, 32'h8001_1234, o);
      e = exp_q.pop_front();
      checks++; if (o.req !== 4) begin failures++; $display("FAIL lh_req_cycles got=%0d want=4", o.req); end
      checks++; if (o.stall_lo !== 0) begin failures++; $display("FAIL lh_stall_gap got=%0d want=0", o.stall_lo); end
      checks++; if (o.lat !== e.lat) begin failures++; $display("FAIL lh_latency got=%0d want=%0d", o.lat, e.lat); end
      checks++; if (o.ld !== e.ld) begin failures++; $display("FAIL lh_data got=%h want=%h", o.ld, e.ld); end
   endtask

   task automatic test_misalign;
      obs_t o;
      exp_t e;
      issue(1'b1, 1'b0, 3'b010, 32'h3002, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      exp_q.push_back('{ld: model_ld, mis: 1'b1, berr: 1'b0, lat: 1});
      serve(0, 1'b1, 1'b1, 32'hDEAD_BEEF, o);
      e = exp_q.pop_front();
      checks++; if (o.req !== 0) begin failures++; $display("FAIL mis_req got=%0d want=0", o.req); end
`else
      model_ld = 32'hDEAD_BEEF;
      exp_q.push_back('{ld: model_ld, mis: 1'b0, berr: 1'b0, lat: 3});
      serve(0, 1'b1, 1'b1, 32'hDEAD_BEEF, o);
      e = exp_q.pop_front();
      checks++; if ({o.addr, o.be} !== {32'h3000, 4'b1111}) begin failures++;
         $display("FAIL mis_addr got=%h be=%b want=00003000 be=1111", o.addr, o.be); end
`endif
      checks++; if (o.lat !== e.lat) begin failures++; $display("FAIL mis_latency got=%0d want=%0d", o.lat, e.lat); end
      checks++; if ({o.ld, o.mis, o.berr} !== {e.ld, e.mis, e.berr}) begin failures++;
         $display("FAIL mis_result ld=%h mis=%b berr=%b want ld=%h mis=%b berr=%b", o.ld, o.mis, o.berr, e.ld, e.mis, e.berr); end
   endtask

   task automatic test_illegal;
      obs_t o;
      exp_t e;
      issue(1'b0, 1'b1, 3'b100, 32'h6000, 32'h1111_2222);
      exp_q.push_back('{ld: model_ld, mis: 1'b0, berr: 1'b0, lat: 1});
      serve(0, 1'b1, 1'b0, 32'h0, o);
      e = exp_q.pop_front();
      checks++; if ({o.lat, o.req} !== {e.lat, 32'd0}) begin failures++; $display("FAIL ill_st lat=%0d req=%0d want lat=%0d req=0", o.lat, o.req, e.lat); end
      checks++; if (o.ld !== e.ld) begin failures++; $display("FAIL ill_st_data got=%h want=%h", o.ld, e.ld); end
      issue(1'b1, 1'b1, 3'b011, 32'h6000, 32'h0);
      model_ld = 32'h0;
      exp_q.push_back('{ld: model_ld, mis: 1'b0, berr: 1'b0, lat: 1});
      serve(0, 1'b1, 1'b1, 32'h5555_5555, o);
      e = exp_q.pop_front();
      checks++; if ({o.lat, o.req} !== {e.lat, 32'd0}) begin failures++; $display("FAIL ill_ld lat=%0d req=%0d want lat=%0d req=0", o.lat, o.req, e.lat); end
      checks++; if (o.ld !== e.ld) begin failures++; $display("FAIL ill_ld_data got=%h want=%h", o.ld, e.ld); end
   endtask

   task automatic test_no_op;
      obs_t o;
      issue(1'b0, 1'b0, 3'b010, 32'h7000, 32'h0);
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL noop_stall got=%b want=0", stall); end
      serve(0, 1'b1, 1'b1, 32'h0, o);
      checks++; if ({o.lat, o.req} !== {-32'sd1, 32'd0}) begin failures++; $display("FAIL noop_ignored lat=%0d req=%0d want lat=-1 req=0", o.lat, o.req); end
   endtask

   task automatic test_timeout;
      obs_t o;
      exp_t e;
      issue(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0);
      exp_q.push_back('{ld: model_ld, mis: 1'b0, berr: 1'b1, lat: TO + 1});
      serve(0, 1'b0, 1'b0, 32'h0, o);
      e = exp_q.pop_front();
      checks++; if (o.req !== TO) begin failures++; $display("FAIL to_req_cycles got=%0d want=%0d", o.req, TO); end
      checks++; if (o.lat !== e.lat) begin failures++; $display("FAIL to_latency got=%0d want=%0d", o.lat, e.lat); end
      checks++; if ({o.ld, o.berr, o.mis} !== {e.ld, e.berr, e.mis}) begin failures++;
         $display("FAIL to_result ld=%h berr=%b mis=%b want ld=%h berr=%b mis=%b", o.ld, o.berr, o.mis, e.ld, e.berr, e.mis); end
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(posedge clk); #1;
      checks++; if ({load_data, done, mem_req} !== {model_ld, 2'b00}) begin failures++;
         $display("FAIL to_late_rvalid ld=%h done=%b req=%b want ld=%h done=0 req=0", load_data, done, mem_req, model_ld); end
   endtask

   task automatic test_reset_mid;
      issue(1'b1, 1'b0, 3'b010, 32'h5000, 32'h0);
      @(posedge clk); #1;
      start = 1'b0; mem_gnt = mem_req;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      checks++; if ({stall, mem_req} !== 2'b10) begin failures++; $display("FAIL rst_wait_rd stall=%b req=%b want stall=1 req=0", stall, mem_req); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_ld = 32'h0;
      checks++; if ({stall, done, misaligned, bus_err, mem_req, mem_we, mem_be, load_data, mem_addr, mem_wdata} !== 106'b0) begin failures++;
         $display("FAIL rst_mid_outputs stall=%b done=%b ld=%h addr=%h be=%b wd=%h want all 0", stall, done, load_data, mem_addr, mem_be, mem_wdata); end
      mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      mem_rvalid = 1'b0;
      @(posedge clk); #1;
      checks++; if ({load_data, done} !== {model_ld, 1'b0}) begin failures++;
         $display("FAIL rst_late_rvalid ld=%h done=%b want ld=%h done=0", load_data, done, model_ld); end
   endtask

   initial begin
      test_reset();
      test_store_lanes();
      test_load_extend();
      test_gnt_delay();
      test_misalign();
      test_illegal();
      test_no_op();
      test_timeout();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
